// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU request scheduler.
// Holds the scheduler state encoding, the ALU function-code names and the
// default mask of permitted function codes.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_AND = 3'd2;
  localparam logic [2:0] FN_OR  = 3'd3;
  localparam logic [2:0] FN_XOR = 3'd4;
  localparam logic [2:0] FN_NOT = 3'd5;
  localparam logic [2:0] FN_SHL = 3'd6;
  localparam logic [2:0] FN_SHR = 3'd7;

  // Bit k set means function code k may be executed; codes 1, 2 and 5 are reserved.
  localparam logic [7:0] OP_LEGAL_DEFAULT = 8'b1101_1001;

  function automatic logic op_permitted(input logic [7:0] legal, input logic [2:0] op);
    return legal[op];
  endfunction

endpackage

// File: rtl/alu_req_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request starting at ptr and
// wrapping modulo NREQ. Purely combinational; returns a one-hot grant, the
// binary index of the winner and a flag saying whether anyone won.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan ptr, ptr+1, ... and keep the first requester found.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one combinational ALU among NREQ requesters: round-robin grant in
// IDLE, operand capture, LAT-cycle execution in EXEC and a held response in RESP.
// Optional feature macro: ALU_SCHED_OPMASK_EN -- when defined, function codes
// whose OP_LEGAL bit is clear are accepted but answered at once with rsp_err=1.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter  int         NREQ     = 4,
  parameter  int         W        = 8,
  parameter  int         LAT      = 1,
  parameter  logic [7:0] OP_LEGAL = OP_LEGAL_DEFAULT,
  localparam int         IW       = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [2:0]      alu_f,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic            alu_go,
  input  logic [W-1:0]    alu_y,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IW-1:0]   rsp_id,
  output logic [W-1:0]    rsp_y,
  output logic            rsp_err,
  output logic            busy
);

`ifdef ALU_SCHED_OPMASK_EN
  localparam logic [7:0] LEGAL_MASK = OP_LEGAL;
`else
  // Without the mask feature every function code is treated as permitted.
  localparam logic [7:0] LEGAL_MASK = OP_LEGAL | 8'hFF;
`endif

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [IW-1:0] g_q, g_d;
  logic [W-1:0]  y_q, y_d;
  logic          err_q, err_d;

  logic [NREQ-1:0] gnt_vec;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [2:0]      gnt_op;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (gnt_vec),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign gnt_op = req_op[3*gnt_idx +: 3];

  // State register: every flop, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g_q     <= g_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  // Next state: capture on grant, count EXEC cycles, release on response handshake.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
    y_d     = y_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          op_d  = gnt_op;
          a_d   = req_a[W*gnt_idx +: W];
          b_d   = req_b[W*gnt_idx +: W];
          g_d   = gnt_idx;
          cnt_d = '0;
          if (op_permitted(LEGAL_MASK, gnt_op)) begin
            err_d   = 1'b0;
            state_d = EXEC;
          end else begin
            err_d   = 1'b1;
            y_d     = '0;
            state_d = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'(LAT - 1)) begin
          y_d     = alu_y;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          ptr_d   = (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: accept pulse in IDLE (never while in reset), ALU bus in EXEC, response in RESP.
  always_comb begin
    req_ready = '0;
    alu_f     = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_go    = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_y     = '0;
    rsp_err   = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (!rst) req_ready = gnt_vec;
      end
      EXEC: begin
        alu_go = 1'b1;
        alu_f  = op_q;
        alu_a  = a_q;
        alu_b  = b_q;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = g_q;
        rsp_y     = y_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Testbench for alu_req_scheduler: two instances (LAT=1 and LAT=3) exercised
// with directed and $urandom stimulus against a transaction-level model.
module tb_alu_req_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst       [2];
  logic [NREQ-1:0]   req_valid [2];
  logic [NREQ-1:0]   req_ready [2];
  logic [3*NREQ-1:0] req_op    [2];
  logic [W*NREQ-1:0] req_a     [2];
  logic [W*NREQ-1:0] req_b     [2];
  logic [2:0]        alu_f     [2];
  logic [W-1:0]      alu_a     [2];
  logic [W-1:0]      alu_b     [2];
  logic              alu_go    [2];
  logic [W-1:0]      alu_y     [2];
  logic              rsp_valid [2];
  logic              rsp_ready [2];
  logic [1:0]        rsp_id    [2];
  logic [W-1:0]      rsp_y     [2];
  logic              rsp_err   [2];
  logic              busy      [2];
  logic [3:0]        exec_cnt  [2];

  int ptr_m [2];
  int checks_total  = 0;
  int checks_passed = 0;

  alu_req_scheduler #(.NREQ(NREQ), .W(W), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_a(req_a[0]), .req_b(req_b[0]),
    .alu_f(alu_f[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
    .alu_go(alu_go[0]), .alu_y(alu_y[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_id(rsp_id[0]), .rsp_y(rsp_y[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  alu_req_scheduler #(.NREQ(NREQ), .W(W), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_a(req_a[1]), .req_b(req_b[1]),
    .alu_f(alu_f[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
    .alu_go(alu_go[1]), .alu_y(alu_y[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_id(rsp_id[1]), .rsp_y(rsp_y[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  // Environment ALU: plain arithmetic per function code.
  function automatic logic [W-1:0] alu_ref(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    case (f)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  // The ALU result also carries how many cycles alu_go has been high, so an
  // early capture produces a visibly different response value.
  always @(posedge clk)
    for (int l = 0; l < 2; l++)
      exec_cnt[l] <= alu_go[l] ? exec_cnt[l] + 4'd1 : 4'd0;

  always_comb
    for (int l = 0; l < 2; l++)
      alu_y[l] = alu_ref(alu_f[l], alu_a[l], alu_b[l]) + W'(exec_cnt[l]);

  function automatic int model_grant(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr + k) % NREQ;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic is_legal(input logic [2:0] op);
`ifdef ALU_SCHED_OPMASK_EN
    logic [7:0] m;
    m = 8'b1101_1001;
    return m[op];
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [63:0] all_outs(input int l);
    return 64'({req_ready[l], alu_f[l], alu_a[l], alu_b[l], alu_go[l],
                rsp_valid[l], rsp_id[l], rsp_y[l], rsp_err[l], busy[l]});
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_random(input int l);
    req_valid[l] = 4'($urandom_range(0, 15));
    req_op[l]    = 12'($urandom);
    req_a[l]     = 32'($urandom);
    req_b[l]     = 32'($urandom);
    rsp_ready[l] = 1'($urandom_range(0, 1));
  endtask

  // One complete transaction on lane l; hold<0 picks a random response stall.
  task automatic applyStimulus(input int l, input logic [NREQ-1:0] mask, input bit dir_en,
                               input logic [2:0] dir_op, input logic [W-1:0] dir_a,
                               input logic [W-1:0] dir_b, input int hold);
    int g, lat, nh;
    logic [2:0] op;
    logic [W-1:0] a, b, ey;
    logic legal;
    lat = (l == 0) ? 1 : 3;
    tick();
    drive_random(l);
    req_valid[l] = mask;
    g = model_grant(mask, ptr_m[l]);
    if (dir_en) begin
      req_op[l][3*g +: 3] = dir_op;
      req_a[l][W*g +: W]  = dir_a;
      req_b[l][W*g +: W]  = dir_b;
    end
    #2;
    op = req_op[l][3*g +: 3];
    a  = req_a[l][W*g +: W];
    b  = req_b[l][W*g +: W];
    checkOutput("grant", 64'(req_ready[l]), 64'(4'b0001 << g));
    checkOutput("idle_flags", 64'({busy[l], rsp_valid[l], alu_go[l]}), 64'(0));
    legal = is_legal(op);
    if (legal) begin
      for (int c = 0; c < lat; c++) begin
        tick();
        drive_random(l);
        #2;
        checkOutput("exec_flags", 64'({alu_go[l], req_ready[l], rsp_valid[l], busy[l]}),
                    64'({1'b1, 4'b0000, 1'b0, 1'b1}));
        checkOutput("exec_bus", 64'({alu_f[l], alu_a[l], alu_b[l]}), 64'({op, a, b}));
      end
    end
    ey = legal ? alu_ref(op, a, b) + W'(lat - 1) : '0;
    nh = (hold < 0) ? int'($urandom_range(0, 2)) : hold;
    for (int h = 0; h <= nh; h++) begin
      tick();
      drive_random(l);
      rsp_ready[l] = (h == nh);
      #2;
      checkOutput("rsp", 64'({rsp_valid[l], rsp_id[l], rsp_y[l], rsp_err[l], alu_go[l], req_ready[l], busy[l]}),
                  64'({1'b1, 2'(g), ey, ~legal, 1'b0, 4'b0000, 1'b1}));
    end
    ptr_m[l] = (g + 1) % NREQ;
  endtask

  task automatic resetAll();
    tick();
    for (int l = 0; l < 2; l++) begin
      rst[l] = 1'b1; req_valid[l] = 4'hF; rsp_ready[l] = 1'b0;
    end
    #2;
    for (int l = 0; l < 2; l++) checkOutput("rst_ready", 64'(req_ready[l]), 64'(0));
    tick();
    #2;
    for (int l = 0; l < 2; l++) checkOutput("rst_outs", all_outs(l), 64'(0));
    tick();
    for (int l = 0; l < 2; l++) begin
      rst[l] = 1'b0; req_valid[l] = '0;
    end
    #2;
    for (int l = 0; l < 2; l++) begin
      checkOutput("post_rst", all_outs(l), 64'(0));
      ptr_m[l] = 0;
    end
  endtask

  // Reset hits an operation in EXEC: no response may appear and ptr restarts at 0.
  task automatic midExecReset(input int l);
    tick();
    drive_random(l);
    req_valid[l] = 4'b1000;
    req_op[l][11:9] = 3'd0;
    #2;
    checkOutput("mx_grant", 64'(req_ready[l]), 64'(4'b1000));
    tick();
    drive_random(l);
    req_valid[l] = 4'b1000;
    #2;
    checkOutput("mx_exec", 64'(alu_go[l]), 64'(1));
    tick();
    rst[l] = 1'b1;
    req_valid[l] = 4'b1000;
    #2;
    checkOutput("mx_rst_ready", 64'(req_ready[l]), 64'(0));
    tick();
    #2;
    checkOutput("mx_rst_outs", all_outs(l), 64'(0));
    tick();
    rst[l] = 1'b0;
    req_valid[l] = '0;
    #2;
    checkOutput("mx_post", all_outs(l), 64'(0));
    ptr_m[l] = 0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int l = 0; l < 2; l++) begin
      rst[l] = 1'b1; req_valid[l] = '0; req_op[l] = '0;
      req_a[l] = '0; req_b[l] = '0; rsp_ready[l] = 1'b0;
    end
    resetAll();

    $display("[TB] lane LAT=1: fairness, single op, reserved op, random");
    repeat (5) applyStimulus(0, 4'hF, 1'b0, 3'd0, 8'h00, 8'h00, 0);
    applyStimulus(0, 4'b0100, 1'b1, 3'b011, 8'h0F, 8'h01, 3);
    applyStimulus(0, 4'b0001, 1'b1, 3'b101, 8'h5A, 8'h33, 1);
    repeat (40) applyStimulus(0, 4'($urandom_range(1, 15)), 1'b0, 3'd0, 8'h00, 8'h00, -1);

    $display("[TB] lane LAT=3: latency, mid-exec reset, reserved op, random");
    applyStimulus(1, 4'b0001, 1'b1, 3'b000, 8'h10, 8'h22, 1);
    applyStimulus(1, 4'b0010, 1'b1, 3'b100, 8'hC3, 8'h3C, 0);
    midExecReset(1);
    applyStimulus(1, 4'b1010, 1'b0, 3'd0, 8'h00, 8'h00, 0);
    applyStimulus(1, 4'b1000, 1'b0, 3'd0, 8'h00, 8'h00, 0);
    applyStimulus(1, 4'b0100, 1'b1, 3'b101, 8'h81, 8'h7E, 2);
    repeat (40) applyStimulus(1, 4'($urandom_range(1, 15)), 1'b0, 3'd0, 8'h00, 8'h00, -1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
